// File: rtl/ifetch_queue_pkg.sv
// Shared encodings for the instruction prefetch queue: bus access types, MMU
// fault codes, controller states and the queue entry layout.
package ifetch_queue_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_NONE = 2'd0,
        MEM_ACCESS_R    = 2'd1,
        MEM_ACCESS_W    = 2'd2,
        MEM_ACCESS_X    = 2'd3
    } mem_access_t;

    typedef enum logic [1:0] {
        MMU_EXCEPTION_NONE             = 2'd0,
        MMU_EXCEPTION_TLB_MISS         = 2'd1,
        MMU_EXCEPTION_ACCESS_VIOLATION = 2'd2,
        MMU_EXCEPTION_PAGE_FAULT       = 2'd3
    } mmu_exception_t;

    localparam int MMU_EXC_W = $bits(mmu_exception_t);

    typedef enum logic [1:0] {
        IFQ_IDLE    = 2'd0,
        IFQ_FETCH   = 2'd1,
        IFQ_DISCARD = 2'd2
    } ifq_state_t;

    // Queue entries are packed as {fault, pc, data}, data in the low bits.
    function automatic int ifq_entry_w(int data_w, int addr_w);
        return MMU_EXC_W + addr_w + data_w;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with registered count; clear flushes it and wins over push/pop.
// Head data (dout) is read straight from storage.
module ifq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear && !res) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (res || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch unit: issues sequential execute reads ahead of the core
// and buffers {pc, word, fault} so the core pops instructions instead of fetching.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 res,
    output logic [ADDR_W-1:0]    db_addr,
    output mem_access_t          db_accessType,
    input  logic [DATA_W-1:0]    db_dataIn,
    input  logic                 db_ready,
    input  mmu_exception_t       mmu_exception,
    input  logic                 bus_yield,
    output logic                 fetch_busy,
    output logic                 ins_valid,
    output logic [DATA_W-1:0]    ins_data,
    output logic [ADDR_W-1:0]    ins_pc,
    output mmu_exception_t       ins_fault,
    input  logic                 ins_take,
    input  logic                 redirect,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output ifq_state_t           dbg_state
);
    localparam int ENTRY_W = ifq_entry_w(DATA_W, ADDR_W);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(DATA_W / 8);

    ifq_state_t          state, state_d;
    logic [ADDR_W-1:0]   fetch_pc, fetch_pc_d;
    logic [ADDR_W-1:0]   req_addr, req_addr_d;
    logic                fault_stop, fault_stop_d;
    logic                q_push, q_pop, q_clear;
    logic [ENTRY_W-1:0]  q_din, q_dout;
    logic [CNT_W-1:0]    q_count;
    logic [CNT_W:0]      cnt_after;
    logic                requesting;

    ifq_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .res   (res),
        .clear (q_clear),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_din),
        .dout  (q_dout),
        .count (q_count)
    );

    // Handshake: ins_valid/ins_data/ins_pc/ins_fault describe the head entry;
    // the head is consumed on a rising edge where ins_valid and ins_take are both
    // high (and no redirect), and ins_take is ignored while ins_valid is low.
    assign ins_valid  = (q_count != '0);
    assign ins_data   = q_dout[DATA_W-1:0];
    assign ins_pc     = q_dout[DATA_W +: ADDR_W];
    assign ins_fault  = ins_valid ? mmu_exception_t'(q_dout[DATA_W+ADDR_W +: MMU_EXC_W])
                                  : MMU_EXCEPTION_NONE;
    assign q_pop      = ins_take && ins_valid && !redirect;

    assign requesting    = (state == IFQ_FETCH) || (state == IFQ_DISCARD);
    assign fetch_busy    = requesting;
    assign db_addr       = requesting ? req_addr : '0;
    assign db_accessType = requesting ? MEM_ACCESS_X : MEM_ACCESS_NONE;
    assign dbg_state     = state;

    // Occupancy after this cycle's push and pop, used to decide back-to-back issue.
    assign cnt_after = {1'b0, q_count} + (CNT_W+1)'(1) - (CNT_W+1)'(q_pop);

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= IFQ_IDLE;
            fetch_pc   <= RESET_PC;
            req_addr   <= '0;
            fault_stop <= 1'b0;
        end else begin
            state      <= state_d;
            fetch_pc   <= fetch_pc_d;
            req_addr   <= req_addr_d;
            fault_stop <= fault_stop_d;
        end
    end

    always_comb begin
        state_d      = state;
        fetch_pc_d   = fetch_pc;
        req_addr_d   = req_addr;
        fault_stop_d = fault_stop;
        q_push       = 1'b0;
        q_clear      = 1'b0;
        q_din        = {MMU_EXCEPTION_NONE, req_addr, db_dataIn};

        if (redirect) begin
            q_clear      = 1'b1;
            fetch_pc_d   = redirect_pc;
            fault_stop_d = 1'b0;
            // A request that has not finished must still be waited out.
            if (requesting && !db_ready && (mmu_exception == MMU_EXCEPTION_NONE)) begin
                state_d = IFQ_DISCARD;
            end else begin
                state_d = IFQ_IDLE;
            end
        end else begin
            case (state)
                IFQ_IDLE: begin
                    if (!bus_yield && !fault_stop && (q_count < CNT_W'(DEPTH))) begin
                        state_d    = IFQ_FETCH;
                        req_addr_d = fetch_pc;
                    end
                end
                IFQ_FETCH: begin
                    if (mmu_exception != MMU_EXCEPTION_NONE) begin
                        q_push       = 1'b1;
                        q_din        = {mmu_exception, req_addr, {DATA_W{1'b0}}};
                        fault_stop_d = 1'b1;
                        state_d      = IFQ_IDLE;
                    end else if (db_ready) begin
                        q_push     = 1'b1;
                        fetch_pc_d = req_addr + PC_STEP;
                        if ((cnt_after < (CNT_W+1)'(DEPTH)) && !bus_yield) begin
                            req_addr_d = req_addr + PC_STEP;
                        end else begin
                            state_d = IFQ_IDLE;
                        end
                    end
                end
                IFQ_DISCARD: begin
                    if (db_ready || (mmu_exception != MMU_EXCEPTION_NONE)) begin
                        state_d = IFQ_IDLE;
                    end
                end
                default: state_d = IFQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: sequential prefetch, streaming pops, redirect
// with discard, MMU fault stop, bus yield, mid-request reset and PC wrap.
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic                clk = 1'b0;
    logic                res = 1'b1;
    logic [ADDR_W-1:0]   db_addr;
    mem_access_t         db_accessType;
    logic [DATA_W-1:0]   db_dataIn;
    logic                db_ready = 1'b0;
    mmu_exception_t      mmu_exception = MMU_EXCEPTION_NONE;
    logic                bus_yield = 1'b0;
    logic                fetch_busy;
    logic                ins_valid;
    logic [DATA_W-1:0]   ins_data;
    logic [ADDR_W-1:0]   ins_pc;
    mmu_exception_t      ins_fault;
    logic                ins_take = 1'b0;
    logic                redirect = 1'b0;
    logic [ADDR_W-1:0]   redirect_pc = '0;
    ifq_state_t          dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    ifetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk           (clk),
        .res           (res),
        .db_addr       (db_addr),
        .db_accessType (db_accessType),
        .db_dataIn     (db_dataIn),
        .db_ready      (db_ready),
        .mmu_exception (mmu_exception),
        .bus_yield     (bus_yield),
        .fetch_busy    (fetch_busy),
        .ins_valid     (ins_valid),
        .ins_data      (ins_data),
        .ins_pc        (ins_pc),
        .ins_fault     (ins_fault),
        .ins_take      (ins_take),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model: each word is a fixed function of its address.
    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign db_dataIn = word_of(db_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_type"}, 64'(db_accessType), 64'(MEM_ACCESS_NONE));
        chk({tag, "_addr"}, 64'(db_addr), 64'h0);
        chk({tag, "_busy"}, 64'(fetch_busy), 64'h0);
    endtask

    task automatic chk_req(input string tag, input logic [ADDR_W-1:0] a);
        chk({tag, "_type"}, 64'(db_accessType), 64'(MEM_ACCESS_X));
        chk({tag, "_addr"}, 64'(db_addr), 64'(a));
        chk({tag, "_busy"}, 64'(fetch_busy), 64'h1);
    endtask

    task automatic chk_head(input string tag, input logic [ADDR_W-1:0] pc,
                            input logic [DATA_W-1:0] data, input mmu_exception_t f);
        chk({tag, "_valid"}, 64'(ins_valid), 64'h1);
        chk({tag, "_pc"},    64'(ins_pc), 64'(pc));
        chk({tag, "_data"},  64'(ins_data), 64'(data));
        chk({tag, "_fault"}, 64'(ins_fault), 64'(f));
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_pc;

        // Reset, then fill the queue with a zero-wait bus and no pops.
        res = 1'b1;
        step();
        chk_idle_bus("rst");
        chk("rst_valid", 64'(ins_valid), 64'h0);
        chk("rst_fault", 64'(ins_fault), 64'(MMU_EXCEPTION_NONE));
        chk("rst_state", 64'(dbg_state), 64'(IFQ_IDLE));
        res      = 1'b0;
        db_ready = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            chk_req($sformatf("fill%0d", i), ADDR_W'(4 * i));
            step();
        end
        chk_idle_bus("full");
        chk_head("full_head", 32'h0, word_of(32'h0), MMU_EXCEPTION_NONE);
        step();
        chk_idle_bus("full_hold");

        // Streaming: pop every cycle, PCs must stay sequential with no bubbles.
        exp_pc = '0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stream%0d_valid", i), 64'(ins_valid), 64'h1);
            chk($sformatf("stream%0d_pc", i), 64'(ins_pc), 64'(exp_pc));
            chk($sformatf("stream%0d_data", i), 64'(ins_data), 64'(word_of(exp_pc)));
            ins_take = 1'b1;
            step();
            exp_pc = exp_pc + 32'd4;
        end
        ins_take = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk_idle_bus("refill");
        chk_head("refill_head", exp_pc, word_of(exp_pc), MMU_EXCEPTION_NONE);

        // Redirect to 0x8 from a full idle queue, then redirect to 0x100 mid-request.
        db_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h8;
        step();
        redirect = 1'b0;
        chk("rd8_valid", 64'(ins_valid), 64'h0);
        step();
        chk_req("rd8_req", 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk_req("disc_w1", 32'h8);
        chk("disc_state", 64'(dbg_state), 64'(IFQ_DISCARD));
        chk("disc_valid", 64'(ins_valid), 64'h0);
        step();
        chk_req("disc_w2", 32'h8);
        db_ready = 1'b1;
        step();
        db_ready = 1'b0;
        chk_idle_bus("disc_done");
        chk("disc_dropped", 64'(ins_valid), 64'h0);
        step();
        chk_req("r100_req", 32'h100);
        db_ready = 1'b1;
        step();
        chk_head("r100_head", 32'h100, word_of(32'h100), MMU_EXCEPTION_NONE);
        chk_req("r104_req", 32'h104);

        // Redirect coinciding with db_ready drops the response, no discard state.
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        db_ready = 1'b0;
        chk_idle_bus("rd10");
        chk("rd10_valid", 64'(ins_valid), 64'h0);
        step();
        chk_req("r10_req", 32'h10);
        mmu_exception = MMU_EXCEPTION_TLB_MISS;
        step();
        mmu_exception = MMU_EXCEPTION_NONE;
        chk_head("fault_head", 32'h10, 32'h0, MMU_EXCEPTION_TLB_MISS);
        chk_idle_bus("fault_stop0");
        db_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk_idle_bus($sformatf("fault_stop%0d", i));
        end
        chk("fault_single", 64'(ins_pc), 64'h10);
        db_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        chk("rd80_valid", 64'(ins_valid), 64'h0);
        step();
        chk_req("r80_req", 32'h80);
        db_ready = 1'b1;
        step();
        chk_head("r80_head", 32'h80, word_of(32'h80), MMU_EXCEPTION_NONE);
        chk_req("r84_req", 32'h84);

        // Bus yield: the outstanding request finishes, nothing new is started.
        db_ready  = 1'b0;
        bus_yield = 1'b1;
        step();
        chk_req("yield_w1", 32'h84);
        step();
        chk_req("yield_w2", 32'h84);
        db_ready = 1'b1;
        step();
        db_ready = 1'b0;
        chk_idle_bus("yield_done");
        step();
        chk_idle_bus("yield_hold1");
        step();
        chk_idle_bus("yield_hold2");
        bus_yield = 1'b0;
        step();
        chk_req("r88_req", 32'h88);

        // Synchronous reset in the middle of a request.
        res = 1'b1;
        step();
        chk_idle_bus("midrst");
        chk("midrst_valid", 64'(ins_valid), 64'h0);
        res = 1'b0;
        step();
        chk_req("post_rst_req", 32'h0);

        // PC wrap at the top of the address space.
        db_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        db_ready = 1'b0;
        chk("wrap_rd_valid", 64'(ins_valid), 64'h0);
        step();
        chk_req("wrap_top_req", 32'hFFFF_FFFC);
        db_ready = 1'b1;
        step();
        db_ready = 1'b0;
        chk_head("wrap_head", 32'hFFFF_FFFC, word_of(32'hFFFF_FFFC), MMU_EXCEPTION_NONE);
        chk_req("wrap_next_req", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
